// File: rtl/acc_seq_unit_pkg.sv
// Shared types and constants for the accumulator sequencing unit.
// Op-code enumeration, ALU select encodings, FSM states and the default width.
package acc_seq_unit_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_CLA = 4'd1,
    OP_CLE = 4'd2,
    OP_CMA = 4'd3,
    OP_CME = 4'd4,
    OP_CIR = 4'd5,
    OP_CIL = 4'd6,
    OP_INC = 4'd7,
    OP_SZA = 4'd8,
    OP_SNA = 4'd9,
    OP_SZE = 4'd10,
    OP_ADD = 4'd11,
    OP_AND = 4'd12,
    OP_LDA = 4'd13
  } op_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XFER = 3'b010;
  localparam logic [2:0] ALU_CMPL = 3'b011;
  localparam logic [2:0] ALU_SHR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/acc_seq_unit_flag_gen.sv
// Combinational zero/negative detection on a WIDTH-bit value.
module acc_flag_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic             z,
  output logic             n
);

  assign z = ~|value;
  assign n = value[WIDTH-1];

endmodule

// File: rtl/acc_seq_unit.sv
// Two-state accumulator sequencer driving an external ALU; one op retired every 2 cycles.
// Optional skip tests (SZA/SNA/SZE) are enabled by defining ACC_SKIP_TESTS_EN.
module acc_seq_unit
  import acc_seq_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] dr_in,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_ac,
  output logic [WIDTH-1:0] alu_dr,
  output logic             alu_e,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_co,
  input  logic             alu_ovf,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             flag_co,
  output logic             flag_ovf,
  output logic             flag_n,
  output logic             flag_z,
  output logic             skip,
  output logic             done
);

  state_e           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] dr_q;
  logic             ac_lsb_q, ac_msb_q;

  logic [WIDTH-1:0] ac_nxt;
  logic             e_nxt, wr_flags, co_nxt, ovf_nxt, skip_nxt;
  logic             z_nxt, n_nxt;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_co;

  assign alu_ac = ac;
  assign alu_dr = dr_q;
  assign alu_e  = e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    alu_sel   = ALU_ADD;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_IDLE;
        case (op_q)
          OP_CMA:  alu_sel = ALU_CMPL;
          OP_CIR:  alu_sel = ALU_SHR;
          OP_CIL:  alu_sel = ALU_SHL;
          OP_ADD:  alu_sel = ALU_ADD;
          OP_AND:  alu_sel = ALU_AND;
          OP_LDA:  alu_sel = ALU_XFER;
          default: alu_sel = ALU_ADD;
        endcase
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign {inc_co, inc_sum} = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};

  // Result selection; only committed when the FSM is in EXEC.
  always_comb begin
    ac_nxt   = ac;
    e_nxt    = e;
    wr_flags = 1'b0;
    co_nxt   = 1'b0;
    ovf_nxt  = 1'b0;
    skip_nxt = 1'b0;
    case (op_q)
      OP_CLA: begin
        ac_nxt   = '0;
        wr_flags = 1'b1;
      end
      OP_CLE: e_nxt = 1'b0;
      OP_CME: e_nxt = ~e;
      OP_CMA, OP_AND, OP_LDA: begin
        ac_nxt   = alu_result;
        wr_flags = 1'b1;
      end
      OP_CIR: begin
        ac_nxt   = alu_result;
        e_nxt    = ac_lsb_q;
        wr_flags = 1'b1;
      end
      OP_CIL: begin
        ac_nxt   = alu_result;
        e_nxt    = ac_msb_q;
        wr_flags = 1'b1;
      end
      OP_ADD: begin
        ac_nxt   = alu_result;
        e_nxt    = alu_co;
        co_nxt   = alu_co;
        ovf_nxt  = alu_ovf;
        wr_flags = 1'b1;
      end
      OP_INC: begin
        ac_nxt   = inc_sum;
        e_nxt    = inc_co;
        co_nxt   = inc_co;
        wr_flags = 1'b1;
      end
`ifdef ACC_SKIP_TESTS_EN
      OP_SZA: skip_nxt = ~|ac;
      OP_SNA: skip_nxt = ac[WIDTH-1];
      OP_SZE: skip_nxt = ~e;
`endif
      default: ;
    endcase
  end

  acc_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .value (ac_nxt),
    .z     (z_nxt),
    .n     (n_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 4'd0;
      dr_q     <= '0;
      ac_lsb_q <= 1'b0;
      ac_msb_q <= 1'b0;
      ac       <= '0;
      e        <= 1'b0;
      flag_co  <= 1'b0;
      flag_ovf <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
      skip     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (op_valid && op_ready) begin
        op_q     <= op_code;
        dr_q     <= dr_in;
        ac_lsb_q <= ac[0];
        ac_msb_q <= ac[WIDTH-1];
      end
      if (state == ST_EXEC) begin
        ac   <= ac_nxt;
        e    <= e_nxt;
        done <= 1'b1;
        skip <= skip_nxt;
        if (wr_flags) begin
          flag_co  <= co_nxt;
          flag_ovf <= ovf_nxt;
          flag_n   <= n_nxt;
          flag_z   <= z_nxt;
        end
      end else begin
        done <= 1'b0;
        skip <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_seq_unit.sv
// Directed + random bench for acc_seq_unit with a reference model and result scoreboard.
module tb_acc_seq_unit;
  import acc_seq_unit_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] ac;
    logic         e, co, ovf, n, z, skip;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   op_code;
  logic [W-1:0] dr_in;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_ac, alu_dr;
  logic         alu_e;
  logic [W-1:0] alu_result;
  logic         alu_co, alu_ovf;
  logic [W-1:0] ac;
  logic         e, flag_co, flag_ovf, flag_n, flag_z, skip, done;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];

  logic [W-1:0] m_ac;
  logic         m_e, m_co, m_ovf, m_n, m_z;

  always #5 clk = ~clk;

  acc_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .dr_in(dr_in), .alu_sel(alu_sel), .alu_ac(alu_ac),
    .alu_dr(alu_dr), .alu_e(alu_e), .alu_result(alu_result), .alu_co(alu_co),
    .alu_ovf(alu_ovf), .ac(ac), .e(e), .flag_co(flag_co), .flag_ovf(flag_ovf),
    .flag_n(flag_n), .flag_z(flag_z), .skip(skip), .done(done)
  );

  // Environment ALU
  always_comb begin
    alu_result = alu_ac;
    alu_co     = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_sel)
      3'b000: begin
        {alu_co, alu_result} = {1'b0, alu_ac} + {1'b0, alu_dr};
        alu_ovf = (alu_ac[W-1] == alu_dr[W-1]) && (alu_result[W-1] != alu_ac[W-1]);
      end
      3'b001:  alu_result = alu_ac & alu_dr;
      3'b010:  alu_result = alu_dr;
      3'b011:  alu_result = ~alu_ac;
      3'b100:  alu_result = {alu_e, alu_ac[W-1:1]};
      3'b101:  alu_result = {alu_ac[W-2:0], alu_e};
      default: alu_result = alu_ac;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ac = '0; m_e = 1'b0; m_co = 1'b0; m_ovf = 1'b0; m_n = 1'b0; m_z = 1'b0;
  endtask

  // Predict the retirement of one op, push it, and advance the model.
  task automatic push_expect(input logic [3:0] code, input logic [W-1:0] dr, output logic [2:0] sel);
    exp_t x;
    logic wr;
    logic [W:0] s;
    x = '{ac: m_ac, e: m_e, co: m_co, ovf: m_ovf, n: m_n, z: m_z, skip: 1'b0};
    wr = 1'b0;
    sel = 3'b000;
    case (code)
      4'd1:  begin x.ac = '0; x.co = 0; x.ovf = 0; wr = 1; end
      4'd2:  x.e = 1'b0;
      4'd3:  begin x.ac = ~m_ac; x.co = 0; x.ovf = 0; wr = 1; sel = 3'b011; end
      4'd4:  x.e = ~m_e;
      4'd5:  begin x.ac = {m_e, m_ac[W-1:1]}; x.e = m_ac[0]; x.co = 0; x.ovf = 0; wr = 1; sel = 3'b100; end
      4'd6:  begin x.ac = {m_ac[W-2:0], m_e}; x.e = m_ac[W-1]; x.co = 0; x.ovf = 0; wr = 1; sel = 3'b101; end
      4'd7:  begin s = m_ac + 17'd1; x.ac = s[W-1:0]; x.e = s[W]; x.co = s[W]; x.ovf = 0; wr = 1; end
`ifdef ACC_SKIP_TESTS_EN
      4'd8:  x.skip = (m_ac == 0);
      4'd9:  x.skip = m_ac[W-1];
      4'd10: x.skip = ~m_e;
`endif
      4'd11: begin
        s = {1'b0, m_ac} + {1'b0, dr};
        x.ac = s[W-1:0]; x.e = s[W]; x.co = s[W];
        x.ovf = (m_ac[W-1] == dr[W-1]) && (s[W-1] != m_ac[W-1]);
        wr = 1; sel = 3'b000;
      end
      4'd12: begin x.ac = m_ac & dr; x.co = 0; x.ovf = 0; wr = 1; sel = 3'b001; end
      4'd13: begin x.ac = dr; x.co = 0; x.ovf = 0; wr = 1; sel = 3'b010; end
      default: ;
    endcase
    if (wr) begin
      x.n = x.ac[W-1];
      x.z = (x.ac == 0);
    end
    sb.push_back(x);
    m_ac = x.ac; m_e = x.e; m_co = x.co; m_ovf = x.ovf; m_n = x.n; m_z = x.z;
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where done is visible.
  task automatic run_op(input logic [3:0] code, input logic [W-1:0] dr);
    logic [2:0] sel;
    int cyc;
    cyc = 0;
    while (!op_ready && cyc < 10) begin @(negedge clk); cyc++; end
    check("ready_idle", op_ready, 1);
    op_valid = 1'b1; op_code = code; dr_in = dr;
    push_expect(code, dr, sel);
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    check("ready_busy", op_ready, 0);
    check("alu_sel", alu_sel, sel);
    check("alu_dr", alu_dr, dr);
    check("done_early", done, 0);
    @(posedge clk); @(negedge clk);
    check("done", done, 1);
  endtask

  // Scoreboard: compare on every done pulse.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        x = sb.pop_front();
        check("ac", ac, x.ac);
        check("e", e, x.e);
        check("flag_co", flag_co, x.co);
        check("flag_ovf", flag_ovf, x.ovf);
        check("flag_n", flag_n, x.n);
        check("flag_z", flag_z, x.z);
        check("skip", skip, x.skip);
      end
    end
  end

  initial begin
    logic [2:0] sel_a, sel_b;
    logic [3:0] c;
    logic [W-1:0] d;

    rst_n = 1'b0; op_valid = 1'b0; op_code = 4'd0; dr_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", op_ready, 1);
    check("rst_ac", ac, 0);
    check("rst_e", e, 0);
    check("rst_flags", {flag_co, flag_ovf, flag_n, flag_z}, 0);
    check("rst_skip", skip, 0);
    check("rst_done", done, 0);
    check("rst_dr", alu_dr, 0);
    rst_n = 1'b1;

    run_op(4'd13, 16'h8001);              // LDA, first edge after release
    run_op(4'd1,  16'h0000);              // CLA
    run_op(4'd3,  16'h0000);              // CMA -> FFFF
    run_op(4'd7,  16'h0000);              // INC wraps
    run_op(4'd2,  16'h0000);              // CLE
    run_op(4'd13, 16'h0001);
    run_op(4'd5,  16'h0000);              // CIR -> 0, e=1
    run_op(4'd8,  16'h0000);              // SZA with ac==0
    run_op(4'd9,  16'h0000);
    run_op(4'd10, 16'h0000);
    run_op(4'd2,  16'h0000);
    run_op(4'd10, 16'h0000);
    run_op(4'd13, 16'h7FFF);
    run_op(4'd11, 16'h0001);              // signed overflow
    run_op(4'd9,  16'h0000);
    run_op(4'd11, 16'h8000);              // carry out
    run_op(4'd12, 16'h0F0F);
    run_op(4'd6,  16'h0000);
    run_op(4'd4,  16'h0000);
    run_op(4'd0,  16'h0000);
    run_op(4'd14, 16'h1234);
    run_op(4'd15, 16'h5678);

    // op_valid held through EXEC: second op only after return to IDLE
    op_valid = 1'b1; op_code = 4'd13; dr_in = 16'hA5A5;
    push_expect(4'd13, 16'hA5A5, sel_a);
    @(posedge clk); @(negedge clk);
    op_code = 4'd3; dr_in = 16'h0000;
    check("hold_ready_busy", op_ready, 0);
    check("hold_sel_a", alu_sel, sel_a);
    @(posedge clk); @(negedge clk);
    check("hold_done_a", done, 1);
    check("hold_ready_idle", op_ready, 1);
    push_expect(4'd3, 16'h0000, sel_b);
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    check("hold_ready_busy_b", op_ready, 0);
    check("hold_sel_b", alu_sel, sel_b);
    @(posedge clk); @(negedge clk);
    check("hold_done_b", done, 1);

    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(15, 0));
      d = W'($urandom);
      run_op(c, d);
    end

    // Reset during EXEC of ADD abandons the op
    run_op(4'd13, 16'h1234);
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd11; dr_in = 16'h0101;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ac", ac, 0);
    check("mid_rst_e", e, 0);
    check("mid_rst_flags", {flag_co, flag_ovf, flag_n, flag_z}, 0);
    check("mid_rst_ready", op_ready, 1);
    check("mid_rst_done", done, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
    end
    run_op(4'd7, 16'h0000);
    @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
